// File: rtl/seg7_display_port.sv
// ---------------------------------------------------------------------------
// seg7_display_port
//
// Core-writable 32-bit value shown on an 8-digit multiplexed 7-segment
// display. A write lands in a shadow register at once. The value the scanner
// shows ("display") is only refreshed at a frame boundary, so one frame
// never shows nibbles from two different values.
//
// Parameters
//   DIV_WIDTH  scan prescaler width; each digit is held 2^DIV_WIDTH clocks
//              (must be at least 2)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   we          write strobe from the core
//   wdata[31:0] value written by the core
//   rd_data     readback of the shadow register
//   AN[7:0]     digit enables, active-low; bit i drives nibble i
//   SEG[6:0]    segments {g,f,e,d,c,b,a}, active-low
//   frame_done  one-cycle pulse the cycle after each frame boundary
//
// Configuration
//   SEG7_LEAD_ZERO_BLANK_EN  when defined, digits above the most significant
//                            non-zero nibble are blanked (digit 0 never is)
// ---------------------------------------------------------------------------
module seg7_display_port #(
    parameter int DIV_WIDTH = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        frame_done
);

    localparam logic [DIV_WIDTH-1:0] PRESC_MAX = {DIV_WIDTH{1'b1}};
    localparam logic [DIV_WIDTH-1:0] PRESC_ONE = DIV_WIDTH'(1);

    logic [31:0]          shadow_r;
    logic [31:0]          display_r;
    logic                 pending_r;
    logic [DIV_WIDTH-1:0] presc_r;
    logic [2:0]           digit_idx_r;
    logic [7:0]           an_r;
    logic [6:0]           seg_r;
    logic                 frame_done_r;

    logic                 wrap_s;
    logic                 boundary_s;
    logic [3:0]           nibble_s;
    logic [7:0]           an_next_s;
    logic [6:0]           seg_next_s;

    // Hex digit to active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    // Index of the most significant non-zero nibble; 0 when the value is 0,
    // which keeps digit 0 lit.
    function automatic logic [2:0] top_nibble(input logic [31:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i*4 +: 4] != 4'd0) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction
`endif

    assign wrap_s     = (presc_r == PRESC_MAX);
    assign boundary_s = wrap_s && (digit_idx_r == 3'd7);

    // Decode of the digit currently selected by the scanner.
    always_comb begin
        nibble_s   = display_r[{digit_idx_r, 2'b00} +: 4];
        an_next_s  = ~(8'd1 << digit_idx_r);
        seg_next_s = hex_to_seg(nibble_s);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        if (digit_idx_r > top_nibble(display_r)) begin
            seg_next_s = 7'h7F;
        end else begin
            seg_next_s = hex_to_seg(nibble_s);
        end
`endif
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r     <= {DIV_WIDTH{1'b0}};
            digit_idx_r <= 3'd0;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
            if (wrap_s) begin
                digit_idx_r <= digit_idx_r + 3'd1;
            end else begin
                digit_idx_r <= digit_idx_r;
            end
        end
    end

    // Shadow/display handoff. A write in the boundary cycle goes straight
    // through to the display; otherwise a pending shadow value is copied at
    // the boundary, so only the last write of a frame is ever shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r  <= 32'd0;
            display_r <= 32'd0;
            pending_r <= 1'b0;
        end else if (boundary_s) begin
            pending_r <= 1'b0;
            if (we) begin
                shadow_r  <= wdata;
                display_r <= wdata;
            end else if (pending_r) begin
                display_r <= shadow_r;
            end else begin
                display_r <= display_r;
            end
        end else if (we) begin
            shadow_r  <= wdata;
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Registered display drive and frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r         <= 8'hFF;
            seg_r        <= 7'h7F;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_next_s;
            seg_r        <= seg_next_s;
            frame_done_r <= boundary_s;
        end
    end

    assign rd_data    = shadow_r;
    assign AN         = an_r;
    assign SEG        = seg_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_display_port.sv
// ---------------------------------------------------------------------------
// tb_seg7_display_port
//
// Drives seg7_display_port (DIV_WIDTH=2) with directed scenarios followed by
// random writes and resets. The reference model tracks the number of cycles
// since reset: digit = (t/4) mod 8, and a frame ends when t mod 32 == 31.
// ---------------------------------------------------------------------------
module tb_seg7_display_port;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        frame_done;

    int errors;
    int checks;

    // Model state
    int          m_t;
    logic [31:0] m_shadow;
    logic [31:0] m_display;
    logic        m_pending;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_display_port #(.DIV_WIDTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wdata      (wdata),
        .rd_data    (rd_data),
        .AN         (AN),
        .SEG        (SEG),
        .frame_done (frame_done)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [31:0] v, input int dg);
        logic [31:0] nib;
        nib = (v >> (4 * dg)) & 32'hF;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        begin
            int top;
            top = 0;
            for (int i = 0; i < 8; i++) begin
                if (((v >> (4 * i)) & 32'hF) != 32'd0) top = i;
            end
            if (dg > top) return 7'h7F;
        end
`endif
        return HEX[nib[3:0]];
    endfunction

    // One clock: apply inputs, predict outputs after the edge, compare.
    task automatic step(input logic r, input logic w, input logic [31:0] d);
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_fd;
        int         dg;
        reset = r;
        we    = w;
        wdata = d;
        if (r) begin
            e_an  = 8'hFF;
            e_seg = 7'h7F;
            e_fd  = 1'b0;
        end else begin
            dg    = (m_t / 4) % 8;
            e_an  = ~(8'd1 << dg);
            e_seg = exp_seg(m_display, dg);
            e_fd  = ((m_t % 32) == 31);
        end
        if (r) begin
            m_t       = 0;
            m_shadow  = 32'd0;
            m_display = 32'd0;
            m_pending = 1'b0;
        end else begin
            if ((m_t % 32) == 31) begin
                if (w) begin
                    m_shadow  = d;
                    m_display = d;
                end else if (m_pending) begin
                    m_display = m_shadow;
                end
                m_pending = 1'b0;
            end else if (w) begin
                m_shadow  = d;
                m_pending = 1'b1;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
        check("AN", {24'd0, AN}, {24'd0, e_an});
        check("SEG", {25'd0, SEG}, {25'd0, e_seg});
        check("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        check("rd_data", rd_data, m_shadow);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
    endtask

    // Idle until the next cycle is a frame boundary.
    task automatic align_to_boundary();
        while ((m_t % 32) != 31) step(1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        m_t       = 0;
        m_shadow  = 32'd0;
        m_display = 32'd0;
        m_pending = 1'b0;
        reset     = 1'b1;
        we        = 1'b0;
        wdata     = 32'd0;
        #1;

        // Reset, then two full frames of scanning
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        idle(70);

        // Mid-frame write of 7
        idle(5);
        step(1'b0, 1'b1, 32'd7);
        idle(70);

        // Two writes in one frame; only the last is shown
        align_to_boundary();
        idle(6);
        step(1'b0, 1'b1, 32'h12345678);
        idle(3);
        step(1'b0, 1'b1, 32'hDEADBEEF);
        idle(70);

        // Write-through in the boundary cycle
        align_to_boundary();
        step(1'b0, 1'b1, 32'h000000A5);
        idle(70);

        // Reset mid-frame with a pending write
        idle(9);
        step(1'b0, 1'b1, 32'hCAFE0123);
        idle(4);
        step(1'b1, 1'b0, 32'd0);
        idle(70);

        // Reset and write together: write discarded
        step(1'b1, 1'b1, 32'h000000FF);
        idle(40);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic        r;
            logic        w;
            logic [31:0] d;
            r = ($urandom_range(199) == 0);
            w = ($urandom_range(11) == 0);
            d = $urandom;
            if ($urandom_range(2) == 0) d = d >> (4 * $urandom_range(7));
            step(r, w, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
